// File: rtl/core_host.sv
// core_host: initiator side of the three-operand serial-sum interface.
// Accepts one parallel request (a, b, c), sends it to the summing engine as
// three consecutive beats, waits for the engine's result strobe, compares it
// with a locally computed sum and presents result plus error flags on a
// valid/ready response port.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake
//   req_a, req_b, req_c           operands (sampled only at acceptance)
//   core_in_valid, core_in        beat stream to the engine
//   core_out_valid, core_out      single-cycle engine result
//   rsp_valid/rsp_ready           response handshake
//   rsp_sum, rsp_err, rsp_timeout response payload
//   stray                         sticky flag: result strobe seen outside WAIT

package core_host_pkg;

    localparam int unsigned OP_W   = 5;
    localparam int unsigned SUM_W  = 7;
    localparam int unsigned WAIT_W = 8;
    localparam int unsigned GAP_W  = 3;
    localparam int unsigned BEAT_W = 2;

    // Operands still to be sent once the first beat has left
    typedef struct packed {
        logic [OP_W-1:0] b;
        logic [OP_W-1:0] c;
    } pend_t;

    // Response payload
    typedef struct packed {
        logic [SUM_W-1:0] sum;
        logic             err;
        logic             timeout;
    } rsp_t;

endpackage

module core_host
    import core_host_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned GAP     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OP_W-1:0]  req_a,
    input  logic [OP_W-1:0]  req_b,
    input  logic [OP_W-1:0]  req_c,
    output logic             core_in_valid,
    output logic [OP_W-1:0]  core_in,
    input  logic             core_out_valid,
    input  logic [SUM_W-1:0] core_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [SUM_W-1:0] rsp_sum,
    output logic             rsp_err,
    output logic             rsp_timeout,
    output logic             stray
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_RESP,
        ST_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    pend_t               pend_q, pend_d;
    logic [SUM_W-1:0]    exp_q, exp_d;
    logic                civ_q, civ_d;
    logic [OP_W-1:0]     ci_q, ci_d;
    logic                rspv_q, rspv_d;
    rsp_t                rsp_q, rsp_d;
    logic                stray_q, stray_d;

    // Ready is a pure decode of the state register
    assign req_ready     = (state_q == ST_IDLE);

    assign core_in_valid = civ_q;
    assign core_in       = ci_q;
    assign rsp_valid     = rspv_q;
    assign rsp_sum       = rsp_q.sum;
    assign rsp_err       = rsp_q.err;
    assign rsp_timeout   = rsp_q.timeout;
    assign stray         = stray_q;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            wait_q  <= '0;
            gap_q   <= '0;
            pend_q  <= '0;
            exp_q   <= '0;
            civ_q   <= 1'b0;
            ci_q    <= '0;
            rspv_q  <= 1'b0;
            rsp_q   <= '0;
            stray_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            gap_q   <= gap_d;
            pend_q  <= pend_d;
            exp_q   <= exp_d;
            civ_q   <= civ_d;
            ci_q    <= ci_d;
            rspv_q  <= rspv_d;
            rsp_q   <= rsp_d;
            stray_q <= stray_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        gap_d   = gap_q;
        pend_d  = pend_q;
        exp_d   = exp_q;
        civ_d   = civ_q;
        ci_d    = ci_q;
        rspv_d  = rspv_q;
        rsp_d   = rsp_q;
        // A result strobe anywhere but WAIT is only recorded, never consumed
        stray_d = stray_q | (core_out_valid && (state_q != ST_WAIT));

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    pend_d.b = req_b;
                    pend_d.c = req_c;
                    exp_d    = SUM_W'(req_a) + SUM_W'(req_b) + SUM_W'(req_c);
                    // First beat goes out on the cycle after acceptance
                    civ_d    = 1'b1;
                    ci_d     = req_a;
                    beat_d   = '0;
                    state_d  = ST_SEND;
                end
            end

            ST_SEND: begin
                case (beat_q)
                    BEAT_W'(0): begin
                        ci_d   = pend_q.b;
                        beat_d = BEAT_W'(1);
                    end
                    BEAT_W'(1): begin
                        ci_d   = pend_q.c;
                        beat_d = BEAT_W'(2);
                    end
                    default: begin
                        // Last beat on the wire; core_in keeps its value
                        civ_d   = 1'b0;
                        beat_d  = '0;
                        wait_d  = '0;
                        state_d = ST_WAIT;
                    end
                endcase
            end

            ST_WAIT: begin
                // A result in the final cycle still beats the timeout
                if (core_out_valid) begin
                    rsp_d.sum     = core_out;
                    rsp_d.err     = (core_out != exp_q);
                    rsp_d.timeout = 1'b0;
                    rspv_d        = 1'b1;
                    state_d       = ST_RESP;
                end else if (wait_q == WAIT_LAST) begin
                    rsp_d.sum     = '0;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                    rspv_d        = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    rspv_d  = 1'b0;
                    gap_d   = '0;
                    state_d = ST_GAP;
                end
            end

            ST_GAP: begin
                // Idle time that lets the engine settle before the next request
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_core_host.sv
// tb_core_host: self-checking bench for core_host with a behavioural
// summing engine (echo / forced value / silent, programmable strobe delay).
module tb_core_host;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned GAP     = 1;
    // Cycles from acceptance edge to rsp_valid: beats 1..3, WAIT from 4
    localparam int LAT_NOM = 7;
    localparam int LAT_TMO = 4 + TIMEOUT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [4:0] req_a = '0, req_b = '0, req_c = '0;
    logic       core_in_valid;
    logic [4:0] core_in;
    logic       core_out_valid;
    logic [6:0] core_out;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [6:0] rsp_sum;
    logic       rsp_err;
    logic       rsp_timeout;
    logic       stray;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    core_host #(.TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_c          (req_c),
        .core_in_valid  (core_in_valid),
        .core_in        (core_in),
        .core_out_valid (core_out_valid),
        .core_out       (core_out),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_sum        (rsp_sum),
        .rsp_err        (rsp_err),
        .rsp_timeout    (rsp_timeout),
        .stray          (stray)
    );

    // Behavioural engine: mode 0 echoes the beat sum, 1 returns eng_force,
    // 2 never answers. Strobe comes eng_delay cycles after the first beat.
    int         eng_mode  = 0;
    logic [6:0] eng_force = '0;
    int         eng_delay = 5;
    int         eng_cnt   = 0;
    int         eng_acc   = 0;
    logic       eng_valid = 1'b0;
    logic [6:0] eng_data  = '0;
    logic       spur      = 1'b0;

    assign core_out_valid = eng_valid | spur;
    assign core_out       = eng_data;

    always @(negedge clk) begin
        eng_valid = 1'b0;
        if (!rst_n) begin
            eng_cnt = 0;
            eng_acc = 0;
        end else begin
            if (eng_cnt > 0) begin
                eng_cnt = eng_cnt - 1;
                if (eng_cnt == 0 && eng_mode != 2) begin
                    eng_valid = 1'b1;
                    eng_data  = (eng_mode == 1) ? eng_force : 7'(eng_acc);
                end
            end
            if (core_in_valid) begin
                if (eng_cnt == 0) begin
                    eng_acc = int'(core_in);
                    eng_cnt = eng_delay;
                end else begin
                    eng_acc = eng_acc + int'(core_in);
                end
            end
        end
    end

    // Observations of the most recent transaction
    int         obs_n, obs_first, obs_last, obs_lat, obs_gap;
    int         obs_unstable, obs_ready_bad, obs_hs_bad;
    logic [4:0] obs_beat [3];
    logic [6:0] obs_sum;
    logic       obs_err, obs_tmo;

    // Drive one request at a negedge and observe it until req_ready returns
    task automatic run_txn(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                           input int rdy_delay, input bit hold_valid,
                           input logic [4:0] na, input logic [4:0] nb, input logic [4:0] nc,
                           input bit spur_gap);
        int cyc;
        obs_n = 0; obs_first = -1; obs_last = -1; obs_unstable = 0;
        obs_ready_bad = 0; obs_hs_bad = 0;
        for (int i = 0; i < 3; i++) obs_beat[i] = 'x;
        cyc = 0;
        while (!req_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b1; req_a = a; req_b = b; req_c = c;
        @(negedge clk);
        if (hold_valid) begin
            req_a = na; req_b = nb; req_c = nc;
        end else begin
            req_valid = 1'b0;
            req_a = 5'($urandom); req_b = 5'($urandom); req_c = 5'($urandom);
        end
        cyc = 1;
        while (!rsp_valid && cyc < 60) begin
            if (core_in_valid) begin
                if (obs_n < 3) obs_beat[obs_n] = core_in;
                if (obs_n == 0) obs_first = cyc;
                obs_last = cyc;
                obs_n++;
            end
            if (req_ready) obs_ready_bad++;
            @(negedge clk);
            cyc++;
        end
        obs_lat = cyc;
        obs_sum = rsp_sum; obs_err = rsp_err; obs_tmo = rsp_timeout;
        for (int k = 0; k < rdy_delay; k++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_sum !== obs_sum || rsp_err !== obs_err || rsp_timeout !== obs_tmo)
                obs_unstable++;
            if (req_ready || core_in_valid) obs_ready_bad++;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        if (rsp_valid || req_ready) obs_hs_bad++;
        if (spur_gap) spur = 1'b1;
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            if (core_in_valid) obs_ready_bad++;
            @(negedge clk);
            spur = 1'b0;
            cyc++;
        end
        spur = 1'b0;
        obs_gap = cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({req_ready, core_in_valid, core_in, rsp_valid} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
            failed++;
            $display("FAIL reset_ctrl: got %b expected %b",
                     {req_ready, core_in_valid, core_in, rsp_valid}, 8'b1000_0000);
        end
        tests++;
        if ({rsp_sum, rsp_err, rsp_timeout, stray} !== 10'd0) begin
            failed++;
            $display("FAIL reset_rsp: got %b expected 0", {rsp_sum, rsp_err, rsp_timeout, stray});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        eng_mode = 0; eng_delay = 5;
        run_txn(5'd1, 5'd2, 5'd3, 0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tests++;
        if (obs_n != 3 || obs_first != 1 || obs_last != 3 ||
            {obs_beat[0], obs_beat[1], obs_beat[2]} !== {5'd1, 5'd2, 5'd3}) begin
            failed++;
            $display("FAIL basic_beats: got n=%0d first=%0d last=%0d beats=%0d,%0d,%0d expected 3 1 3 1,2,3",
                     obs_n, obs_first, obs_last, obs_beat[0], obs_beat[1], obs_beat[2]);
        end
        tests++;
        if ({obs_sum, obs_err, obs_tmo} !== {7'd6, 1'b0, 1'b0}) begin
            failed++;
            $display("FAIL basic_rsp: got sum=%0d err=%b tmo=%b expected 6 0 0", obs_sum, obs_err, obs_tmo);
        end
        tests++;
        if (obs_lat != LAT_NOM) begin
            failed++;
            $display("FAIL basic_latency: got %0d expected %0d", obs_lat, LAT_NOM);
        end
        tests++;
        if (obs_gap != int'(GAP) || obs_hs_bad != 0 || obs_ready_bad != 0) begin
            failed++;
            $display("FAIL basic_gap: got gap=%0d hs_bad=%0d ready_bad=%0d expected %0d 0 0",
                     obs_gap, obs_hs_bad, obs_ready_bad, GAP);
        end
    endtask

    task automatic test_max();
        eng_mode = 0;
        run_txn(5'd31, 5'd31, 5'd31, 1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tests++;
        if ({obs_sum, obs_err, obs_tmo} !== {7'h5D, 1'b0, 1'b0}) begin
            failed++;
            $display("FAIL max_rsp: got sum=%0d err=%b tmo=%b expected 93 0 0", obs_sum, obs_err, obs_tmo);
        end
    endtask

    task automatic test_mismatch();
        eng_mode = 1; eng_force = 7'd50;
        run_txn(5'd1, 5'd2, 5'd3, 0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tests++;
        if ({obs_sum, obs_err, obs_tmo} !== {7'd50, 1'b1, 1'b0} || obs_lat != LAT_NOM) begin
            failed++;
            $display("FAIL mismatch_rsp: got sum=%0d err=%b tmo=%b lat=%0d expected 50 1 0 %0d",
                     obs_sum, obs_err, obs_tmo, obs_lat, LAT_NOM);
        end
        eng_mode = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [4:0] a, b, c;
            int         exp_total, rd;
            logic [6:0] exp_sum;
            logic       exp_err;
            a = 5'($urandom); b = 5'($urandom); c = 5'($urandom);
            rd = int'($urandom_range(0, 4));
            exp_total = int'(a) + int'(b) + int'(c);
            eng_mode = int'($urandom_range(0, 1));
            eng_force = (i % 5 == 0) ? 7'(exp_total) : 7'($urandom_range(0, 127));
            exp_sum = (eng_mode == 1) ? eng_force : 7'(exp_total);
            exp_err = (int'(exp_sum) != exp_total);
            run_txn(a, b, c, rd, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
            tests++;
            if ({obs_sum, obs_err, obs_tmo} !== {exp_sum, exp_err, 1'b0} || obs_lat != LAT_NOM ||
                obs_unstable != 0 ||
                {obs_beat[0], obs_beat[1], obs_beat[2]} !== {a, b, c}) begin
                failed++;
                $display("FAIL random_%0d: got sum=%0d err=%b tmo=%b lat=%0d unstable=%0d expected %0d %b 0 %0d 0",
                         i, obs_sum, obs_err, obs_tmo, obs_lat, obs_unstable, exp_sum, exp_err, LAT_NOM);
            end
        end
        eng_mode = 0;
    endtask

    task automatic test_timeout();
        eng_mode = 2;
        run_txn(5'd4, 5'd9, 5'd1, 2, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tests++;
        if ({obs_sum, obs_err, obs_tmo} !== {7'd0, 1'b1, 1'b1} || obs_lat != LAT_TMO || obs_unstable != 0) begin
            failed++;
            $display("FAIL timeout_rsp: got sum=%0d err=%b tmo=%b lat=%0d expected 0 1 1 %0d",
                     obs_sum, obs_err, obs_tmo, obs_lat, LAT_TMO);
        end
        // Strobe in the last WAIT cycle is a normal result
        eng_mode = 0; eng_delay = int'(TIMEOUT) + 2;
        run_txn(5'd10, 5'd20, 5'd30, 0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tests++;
        if ({obs_sum, obs_err, obs_tmo} !== {7'd60, 1'b0, 1'b0} || obs_lat != LAT_TMO) begin
            failed++;
            $display("FAIL timeout_edge: got sum=%0d err=%b tmo=%b lat=%0d expected 60 0 0 %0d",
                     obs_sum, obs_err, obs_tmo, obs_lat, LAT_TMO);
        end
        eng_delay = 5;
    endtask

    task automatic test_back_to_back();
        eng_mode = 0; eng_delay = 5;
        tests++;
        if (stray !== 1'b0) begin
            failed++;
            $display("FAIL b2b_stray_pre: got %b expected 0", stray);
        end
        run_txn(5'd11, 5'd12, 5'd13, 5, 1'b1, 5'd20, 5'd21, 5'd22, 1'b1);
        tests++;
        if (obs_unstable != 0 || obs_ready_bad != 0 || obs_hs_bad != 0) begin
            failed++;
            $display("FAIL b2b_hold: got unstable=%0d ready_bad=%0d hs_bad=%0d expected 0 0 0",
                     obs_unstable, obs_ready_bad, obs_hs_bad);
        end
        tests++;
        if ({obs_sum, obs_err, obs_tmo} !== {7'd36, 1'b0, 1'b0}) begin
            failed++;
            $display("FAIL b2b_first: got sum=%0d err=%b tmo=%b expected 36 0 0", obs_sum, obs_err, obs_tmo);
        end
        tests++;
        if (stray !== 1'b1 || rsp_sum !== 7'd36 || rsp_valid !== 1'b0) begin
            failed++;
            $display("FAIL b2b_stray: got stray=%b sum=%0d valid=%b expected 1 36 0", stray, rsp_sum, rsp_valid);
        end
        run_txn(5'd20, 5'd21, 5'd22, 0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tests++;
        if ({obs_sum, obs_err, obs_tmo} !== {7'd63, 1'b0, 1'b0} || obs_first != 1 || obs_n != 3) begin
            failed++;
            $display("FAIL b2b_second: got sum=%0d err=%b tmo=%b first=%0d n=%0d expected 63 0 0 1 3",
                     obs_sum, obs_err, obs_tmo, obs_first, obs_n);
        end
    endtask

    task automatic test_reset_mid_send();
        int cyc;
        eng_mode = 0; eng_delay = 5;
        cyc = 0;
        while (!req_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b1; req_a = 5'd7; req_b = 5'd8; req_c = 5'd9;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (core_in_valid !== 1'b1 || core_in !== 5'd8) begin
            failed++;
            $display("FAIL midrst_beat2: got valid=%b data=%0d expected 1 8", core_in_valid, core_in);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({req_ready, core_in_valid, core_in, rsp_valid, rsp_sum, rsp_err, rsp_timeout, stray} !==
            {1'b1, 1'b0, 5'd0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0}) begin
            failed++;
            $display("FAIL midrst_outputs: got %b expected 1 followed by zeros",
                     {req_ready, core_in_valid, core_in, rsp_valid, rsp_sum, rsp_err, rsp_timeout, stray});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(5'd4, 5'd5, 5'd6, 1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tests++;
        if ({obs_sum, obs_err, obs_tmo} !== {7'd15, 1'b0, 1'b0} || obs_lat != LAT_NOM || stray !== 1'b0) begin
            failed++;
            $display("FAIL midrst_recover: got sum=%0d err=%b tmo=%b lat=%0d stray=%b expected 15 0 0 %0d 0",
                     obs_sum, obs_err, obs_tmo, obs_lat, stray, LAT_NOM);
        end
    endtask

    task automatic test_late_strobe();
        // Strobe one cycle after the timeout fires lands in RESP
        eng_mode = 0; eng_delay = int'(TIMEOUT) + 3;
        run_txn(5'd2, 5'd2, 5'd2, 2, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tests++;
        if ({obs_sum, obs_err, obs_tmo} !== {7'd0, 1'b1, 1'b1} || obs_lat != LAT_TMO || obs_unstable != 0) begin
            failed++;
            $display("FAIL late_rsp: got sum=%0d err=%b tmo=%b lat=%0d unstable=%0d expected 0 1 1 %0d 0",
                     obs_sum, obs_err, obs_tmo, obs_lat, obs_unstable, LAT_TMO);
        end
        tests++;
        if (stray !== 1'b1) begin
            failed++;
            $display("FAIL late_stray: got %b expected 1", stray);
        end
        eng_delay = 5;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_mismatch();
        test_random();
        test_timeout();
        test_back_to_back();
        test_reset_mid_send();
        test_late_strobe();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
        $fatal(1, "watchdog");
    end

endmodule
